// File: rtl/mod_add_arbiter.sv
// Round-robin arbiter sharing one modular add/sub engine among NREQ requesters.
// Latches the winner's operands, pulses start, waits for done (with watchdog), returns the result.
module mod_add_arbiter #(
  parameter int WIDTH   = 256,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     req_sel,
  input  logic [WIDTH*NREQ-1:0] req_nu_1,
  input  logic [WIDTH*NREQ-1:0] req_nu_2,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rsp_vld,
  output logic [WIDTH-1:0]      rsp_dat,
  output logic [1:0]            eng_sel,
  output logic                  eng_start,
  output logic [WIDTH-1:0]      eng_nu_1,
  output logic [WIDTH-1:0]      eng_nu_2,
  input  logic [WIDTH-1:0]      eng_add_nu,
  input  logic                  eng_done,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [PW-1:0]   rr;
  logic [PW-1:0]   cur;
  logic [PW-1:0]   win;
  logic            found;
  logic [7:0]      wdog;

  // Scan offsets from farthest to nearest so the last hit is the closest to rr.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[(int'(rr) + i) % NREQ]) begin
        win   = PW'((int'(rr) + i) % NREQ);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr          <= '0;
      cur         <= '0;
      wdog        <= '0;
      gnt         <= '0;
      rsp_vld     <= '0;
      rsp_dat     <= '0;
      eng_start   <= 1'b0;
      eng_sel     <= '0;
      eng_nu_1    <= '0;
      eng_nu_2    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      gnt       <= '0;
      rsp_vld   <= '0;
      eng_start <= 1'b0;
      case (state)
        IDLE: if (found) begin
          cur       <= win;
          eng_sel   <= req_sel[2*win +: 2];
          eng_nu_1  <= req_nu_1[WIDTH*win +: WIDTH];
          eng_nu_2  <= req_nu_2[WIDTH*win +: WIDTH];
          gnt       <= ONE << win;
          eng_start <= 1'b1;
          busy      <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: begin
          wdog  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (eng_done) begin
            rsp_dat <= eng_add_nu;
            rsp_vld <= ONE << cur;
            state   <= RESP;
          end else if (wdog == WD_LAST) begin
            timeout_err <= 1'b1;
            rsp_dat     <= '0;
            rsp_vld     <= ONE << cur;
            state       <= RESP;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        RESP: begin
          rr    <= (cur == PW'(NREQ - 1)) ? '0 : cur + PW'(1);
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mod_add_arbiter.md
Name: mod_add_arbiter

Overview:
- Shares one e_mod_add modular add/sub engine among NREQ requesters, e.g. the point-add and point-double sequencers.
- Arbitrates round-robin and latches the winner's operands and sel.
- Issues a one-cycle start to the engine, waits for done_add, then returns the result to the winner with a one-cycle valid pulse.
- A watchdog flags an engine that never completes.

Parameters:
- WIDTH, 256, operand/result width in bits.
- NREQ, 2, number of requesters (legal 2..8).
- TIMEOUT, 64, max cycles in WAIT before abort (legal 2..255).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  in  NREQ  per-requester request level; held until its gnt pulse
- req_sel  in  2*NREQ  sel for requester i at bits [2i+1:2i]
- req_nu_1  in  WIDTH*NREQ  operand 1 for requester i at bits [WIDTH*i +: WIDTH]
- req_nu_2  in  WIDTH*NREQ  operand 2 for requester i, same packing
- gnt  out  NREQ  one-hot, one-cycle pulse: request accepted; requester deasserts req next cycle
- rsp_vld  out  NREQ  one-hot, one-cycle pulse: result ready for requester i
- rsp_dat  out  WIDTH  result, valid while rsp_vld is nonzero, held otherwise
- eng_sel  out  2  to e_mod_add sel
- eng_start  out  1  to e_mod_add start_add, one-cycle pulse
- eng_nu_1  out  WIDTH  to e_mod_add nu_1
- eng_nu_2  out  WIDTH  to e_mod_add nu_2
- eng_add_nu  in  WIDTH  from e_mod_add add_nu
- eng_done  in  1  from e_mod_add done_add
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky: engine did not finish within TIMEOUT

Behaviour:
- Reset values (rst=1 at a clk edge): state=IDLE, gnt=0, rsp_vld=0, rsp_dat=0, eng_start=0, eng_sel=0, eng_nu_1=0, eng_nu_2=0, busy=0, timeout_err=0, rr pointer=0, watchdog count=0. Reset wins over every other event, including mid-WAIT. A done from the engine after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req!=0, pick the winner w = first set bit at or after rr pointer, wrapping modulo NREQ.
  - Register eng_sel, eng_nu_1, eng_nu_2 from w's slice; store w; go to ISSUE.
- ISSUE (exactly one cycle):
  - eng_start=1 and gnt[w]=1; clear the watchdog; go to WAIT.
  - Operands stay stable until the next ISSUE.
- WAIT:
  - eng_done is sampled only here; the engine cannot complete in the ISSUE cycle.
  - eng_done=1: rsp_dat <= eng_add_nu; go to RESP.
  - Otherwise increment the watchdog. When it reaches TIMEOUT-1 without done: timeout_err <= 1, rsp_dat <= 0, go to RESP.
  - eng_done in any other state is ignored.
- RESP (exactly one cycle):
  - rsp_vld[w]=1; rr pointer <= (w+1) mod NREQ; go to IDLE.
- Latency, with req first seen in IDLE at cycle 0:
  - gnt and eng_start at cycle 1.
  - With eng_done at cycle k (k>=2), rsp_vld at cycle k+1.
  - Next grant no earlier than cycle k+3.
- Requests arriving while busy wait, with no loss; req is a level signal.
- A requester whose req stays high past its gnt is treated as a new request.
- Several requests in the same IDLE cycle: only the rr winner is served; the others keep waiting.
- The rr pointer advances only on RESP, including a timeout RESP. No requester waits more than NREQ-1 services.
- timeout_err clears only on rst.

Test Plan:
- Single op: req=01, sel=0, nu_1=5, nu_2=7, engine done 3 cycles after start with add_nu=12 -> gnt=01 at cycle 1, eng_start at cycle 1, rsp_vld=01 with rsp_dat=12 at cycle 5.
- Contention: req=11 held, ptr=0 -> grant order 0,1,0,1; eng operands match each winner's slice; every rsp_vld goes to the correct one-hot bit.
- Fairness: req0 high continuously, req1 rises mid-op -> req1 is served immediately after the current op; req0 is never served twice in a row while req1 waits.
- Timeout: engine never asserts done, TIMEOUT=64 -> timeout_err=1 and rsp_vld pulse with rsp_dat=0 after 64 WAIT cycles; state IDLE; the next request is served normally and timeout_err stays 1.
- Reset mid-WAIT: rst asserted for 1 cycle in WAIT, engine done fires 2 cycles later -> all outputs return to reset values, no rsp_vld, and the stray done is ignored.
- Spurious done: eng_done=1 in IDLE with req=0 -> no state change, rsp_vld stays 0, rsp_dat unchanged.
